// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter: default widths,
// priority-pointer encoding and the hard-wired zero register.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDR_BUS_WIDTH = 5;
  localparam int unsigned ZERO_REG_ADDR      = 0;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_fwd_mux.sv
// Read-port bypass: the zero register always reads 0, and an in-flight write
// to the same register overrides the raw register-file data.
module wb_fwd_mux
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BUS_WIDTH = DEF_ADDR_BUS_WIDTH
) (
  input  logic [ADDR_BUS_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_rd_data,
  input  logic                      i_wr_en,
  input  logic [ADDR_BUS_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  output logic [DATA_WIDTH-1:0]     o_rd_data
);

  localparam logic [ADDR_BUS_WIDTH-1:0] ZERO_ADDR = ADDR_BUS_WIDTH'(ZERO_REG_ADDR);

  always_comb begin
    if (i_rd_addr == ZERO_ADDR)
      o_rd_data = '0;
    else if (i_wr_en && (i_wr_addr == i_rd_addr))
      o_rd_data = i_wr_data;
    else
      o_rd_data = i_rd_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU/LSU) round-robin write-back arbiter with a registered
// register-file write port and bypass on both read ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BUS_WIDTH = DEF_ADDR_BUS_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      alu_valid_i,
  input  logic [ADDR_BUS_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  output logic                      alu_ready_o,
  input  logic                      lsu_valid_i,
  input  logic [ADDR_BUS_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_data_i,
  output logic                      lsu_ready_o,
  output logic                      write_en_o,
  output logic [ADDR_BUS_WIDTH-1:0] write_addr_o,
  output logic [DATA_WIDTH-1:0]     write_data_o,
  input  logic [ADDR_BUS_WIDTH-1:0] read_1_addr_i,
  input  logic [ADDR_BUS_WIDTH-1:0] read_2_addr_i,
  input  logic [DATA_WIDTH-1:0]     read_1_data_i,
  input  logic [DATA_WIDTH-1:0]     read_2_data_i,
  output logic [DATA_WIDTH-1:0]     read_1_data_o,
  output logic [DATA_WIDTH-1:0]     read_2_data_o,
  output logic [1:0]                grant_o
);

  localparam logic [ADDR_BUS_WIDTH-1:0] ZERO_ADDR = ADDR_BUS_WIDTH'(ZERO_REG_ADDR);

  pri_e                      r_pri;
  logic                      r_we;
  logic [ADDR_BUS_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]     r_wdata;

  logic                      w_alu_ready;
  logic                      w_lsu_ready;
  logic                      w_xfer;
  logic [ADDR_BUS_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0]     w_sel_data;

  // Ready is held low through reset so nothing is accepted while it is asserted.
  always_comb begin
    w_alu_ready = 1'b0;
    w_lsu_ready = 1'b0;
    if (!reset_i) begin
      if (alu_valid_i && (!lsu_valid_i || r_pri == PRI_ALU))
        w_alu_ready = 1'b1;
      else if (lsu_valid_i)
        w_lsu_ready = 1'b1;
    end
  end

  assign w_xfer     = w_alu_ready | w_lsu_ready;
  assign w_sel_addr = w_alu_ready ? alu_addr_i : lsu_addr_i;
  assign w_sel_data = w_alu_ready ? alu_data_i : lsu_data_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pri   <= PRI_LSU;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      // Writes to the zero register are accepted but never reach the port.
      r_we <= w_xfer && (w_sel_addr != ZERO_ADDR);
      if (w_xfer) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
      if (w_alu_ready)
        r_pri <= PRI_LSU;
      else if (w_lsu_ready)
        r_pri <= PRI_ALU;
    end
  end

  assign alu_ready_o  = w_alu_ready;
  assign lsu_ready_o  = w_lsu_ready;
  assign grant_o      = {w_lsu_ready, w_alu_ready};
  assign write_en_o   = r_we;
  assign write_addr_o = r_waddr;
  assign write_data_o = r_wdata;

  wb_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BUS_WIDTH(ADDR_BUS_WIDTH)) u_fwd_1 (
    .i_rd_addr (read_1_addr_i),
    .i_rd_data (read_1_data_i),
    .i_wr_en   (r_we),
    .i_wr_addr (r_waddr),
    .i_wr_data (r_wdata),
    .o_rd_data (read_1_data_o)
  );

  wb_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BUS_WIDTH(ADDR_BUS_WIDTH)) u_fwd_2 (
    .i_rd_addr (read_2_addr_i),
    .i_rd_data (read_2_data_i),
    .i_wr_en   (r_we),
    .i_wr_addr (r_waddr),
    .i_wr_data (r_wdata),
    .o_rd_data (read_2_data_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter plus a long both-valid contention run
// checked against a small round-robin model.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          alu_valid_i, lsu_valid_i;
  logic [AW-1:0] alu_addr_i, lsu_addr_i;
  logic [DW-1:0] alu_data_i, lsu_data_i;
  logic          alu_ready_o, lsu_ready_o;
  logic          write_en_o;
  logic [AW-1:0] write_addr_o;
  logic [DW-1:0] write_data_o;
  logic [AW-1:0] read_1_addr_i, read_2_addr_i;
  logic [DW-1:0] read_1_data_i, read_2_data_i;
  logic [DW-1:0] read_1_data_o, read_2_data_o;
  logic [1:0]    grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .write_en_o(write_en_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .read_1_addr_i(read_1_addr_i), .read_2_addr_i(read_2_addr_i),
    .read_1_data_i(read_1_data_i), .read_2_data_i(read_2_data_i),
    .read_1_data_o(read_1_data_o), .read_2_data_o(read_2_data_o),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic          m_pri_lsu;
  logic [AW-1:0] a_addr, l_addr, e_addr;
  logic [DW-1:0] a_data, l_data, e_data;
  logic          e_we;
  logic [1:0]    prev_grant;

  initial begin
    reset_i = 1'b1;
    alu_valid_i = 1'b1; alu_addr_i = 5'd1; alu_data_i = 32'h1;
    lsu_valid_i = 1'b0; lsu_addr_i = '0;   lsu_data_i = '0;
    read_1_addr_i = '0; read_2_addr_i = '0; read_1_data_i = '0; read_2_data_i = '0;
    step(); step();
    chk("rst_alu_ready", alu_ready_o, 0);
    chk("rst_we",        write_en_o, 0);
    chk("rst_waddr",     write_addr_o, 0);
    chk("rst_wdata",     write_data_o, 0);
    alu_valid_i = 1'b0;
    step();
    reset_i = 1'b0;
    step();
    chk("idle_we", write_en_o, 0);

    // Single ALU request
    alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'h0000_00AA;
    #1;
    chk("alu_ready",  alu_ready_o, 1);
    chk("alu_lsu_rdy", lsu_ready_o, 0);
    chk("alu_grant",  grant_o, 2'b01);
    step();
    alu_valid_i = 1'b0;
    chk("alu_we",    write_en_o, 1);
    chk("alu_waddr", write_addr_o, 5);
    chk("alu_wdata", write_data_o, 32'hAA);
    step();
    chk("alu_we_off",   write_en_o, 0);
    chk("alu_addr_hold", write_addr_o, 5);
    chk("alu_data_hold", write_data_o, 32'hAA);

    // Contention: pointer favours LSU after the ALU grant
    alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h22;
    #1;
    chk("c0_grant",     grant_o, 2'b10);
    chk("c0_alu_ready", alu_ready_o, 0);
    step();
    lsu_valid_i = 1'b0;
    #1;
    chk("c1_we",    write_en_o, 1);
    chk("c1_waddr", write_addr_o, 4);
    chk("c1_wdata", write_data_o, 32'h22);
    chk("c1_grant", grant_o, 2'b01);
    step();
    alu_valid_i = 1'b0;
    chk("c2_we",    write_en_o, 1);
    chk("c2_waddr", write_addr_o, 3);
    chk("c2_wdata", write_data_o, 32'h11);

    // Zero-register write accepted but suppressed; pointer still moves to ALU
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd0; lsu_data_i = 32'hFFFF_FFFF;
    #1;
    chk("z_lsu_ready", lsu_ready_o, 1);
    step();
    lsu_valid_i = 1'b0;
    chk("z_we", write_en_o, 0);
    alu_valid_i = 1'b1; alu_addr_i = 5'd6; alu_data_i = 32'h66;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd9; lsu_data_i = 32'h99;
    #1;
    chk("z_next_grant", grant_o, 2'b01);
    step();
    alu_valid_i = 1'b0;
    chk("z_alu_waddr", write_addr_o, 6);
    chk("z_alu_wdata", write_data_o, 32'h66);
    #1;
    chk("z_lsu_grant", grant_o, 2'b10);
    step();
    lsu_valid_i = 1'b0;
    chk("z_lsu_we",    write_en_o, 1);
    chk("z_lsu_waddr", write_addr_o, 9);

    // Forwarding
    alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'h1234;
    step();
    alu_valid_i = 1'b0;
    read_1_addr_i = 5'd7; read_1_data_i = 32'h0;
    read_2_addr_i = 5'd0; read_2_data_i = 32'h5555;
    #1;
    chk("fwd_hit",  read_1_data_o, 32'h1234);
    chk("fwd_zero", read_2_data_o, 32'h0);
    read_1_addr_i = 5'd8; read_1_data_i = 32'hBEEF;
    #1;
    chk("fwd_miss", read_1_data_o, 32'hBEEF);
    step();
    read_1_addr_i = 5'd7; read_1_data_i = 32'h77;
    #1;
    chk("fwd_no_we", read_1_data_o, 32'h77);
    read_1_addr_i = '0; read_2_addr_i = '0;

    // Reset mid-stream: LSU grant leaves pointer at ALU, reset restores LSU
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd10; lsu_data_i = 32'hA0;
    step();
    lsu_valid_i = 1'b0;
    reset_i = 1'b1;
    chk("mr_pulse", write_en_o, 1);
    step();
    chk("mr_we",    write_en_o, 0);
    chk("mr_waddr", write_addr_o, 0);
    reset_i = 1'b0;
    step();
    chk("mr_no_pulse", write_en_o, 0);
    alu_valid_i = 1'b1; alu_addr_i = 5'd1; alu_data_i = 32'h1;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd2; lsu_data_i = 32'h2;
    #1;
    chk("mr_grant", grant_o, 2'b10);
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    step();

    // Sustained both-valid contention against a round-robin model
    m_pri_lsu = 1'b1;
    a_addr = 5'($urandom_range(0, 31)); a_data = $urandom;
    l_addr = 5'($urandom_range(0, 31)); l_data = $urandom;
    e_we = 1'b0; e_addr = '0; e_data = '0; prev_grant = 2'b00;
    for (int i = 0; i < 1000; i++) begin
      alu_valid_i = 1'b1; alu_addr_i = a_addr; alu_data_i = a_data;
      lsu_valid_i = 1'b1; lsu_addr_i = l_addr; lsu_data_i = l_data;
      #1;
      if (i > 0) begin
        chk("rnd_we", write_en_o, e_we);
        if (e_we) begin
          chk("rnd_waddr", write_addr_o, e_addr);
          chk("rnd_wdata", write_data_o, e_data);
        end
        chk("rnd_alternate", (grant_o != prev_grant), 1);
      end
      chk("rnd_grant", grant_o, m_pri_lsu ? 2'b10 : 2'b01);
      prev_grant = grant_o;
      if (m_pri_lsu) begin
        e_addr = l_addr; e_data = l_data;
        l_addr = 5'($urandom_range(0, 31)); l_data = $urandom;
      end else begin
        e_addr = a_addr; e_data = a_data;
        a_addr = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      e_we = (e_addr != 5'd0);
      m_pri_lsu = ~m_pri_lsu;
      step();
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    chk("rnd_last_we", write_en_o, e_we);
    if (e_we) chk("rnd_last_wdata", write_data_o, e_data);
    step();
    chk("rnd_idle_we", write_en_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, register data width; ADDR_BUS_WIDTH, default 5, register address width.
REQ-002 The block SHALL use one clock, clk_i, and a synchronous, active-high reset, reset_i.
REQ-003 The ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- alu_valid_i  in  1  ALU write-back request
- alu_addr_i  in  ADDR_BUS_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU result
- alu_ready_o  out  1  ALU request accepted this cycle
- lsu_valid_i  in  1  load-unit write-back request
- lsu_addr_i  in  ADDR_BUS_WIDTH  load destination register
- lsu_data_i  in  DATA_WIDTH  load data
- lsu_ready_o  out  1  LSU request accepted this cycle
- write_en_o  out  1  register-file write enable
- write_addr_o  out  ADDR_BUS_WIDTH  register-file write address
- write_data_o  out  DATA_WIDTH  register-file write data
- read_1_addr_i, read_2_addr_i  in  ADDR_BUS_WIDTH  register-file read addresses (shared with the register file)
- read_1_data_i, read_2_data_i  in  DATA_WIDTH  raw register-file read data
- read_1_data_o, read_2_data_o  out  DATA_WIDTH  forwarded read data
- grant_o  out  2  {lsu,alu} one-hot grant; 00 when idle

Function
REQ-004 A transfer SHALL occur on a requester when valid and ready are both high at a clock edge.
REQ-005 Ready SHALL be combinational from the valid inputs and the priority pointer, and SHALL never be high on both requesters in the same cycle.
REQ-006 Only one requester valid: that requester's ready SHALL be 1.
REQ-007 Both valid: the requester indicated by the priority pointer SHALL be granted, and the other SHALL see ready=0.
REQ-008 Priority pointer (1-bit state, PRI_ALU/PRI_LSU): after a grant, the pointer SHALL move to the non-granted requester; with no grant, it SHALL hold.
REQ-009 A requester SHALL hold valid, addr and data stable until ready; the block does not check this.
REQ-010 Accepted request: write_en_o, write_addr_o and write_data_o SHALL update at the same edge (latency 1 cycle) and hold for exactly one cycle unless another transfer follows.
REQ-011 A request to address 0 SHALL be accepted (ready=1) but SHALL produce write_en_o=0; the pointer SHALL still advance.
REQ-012 With no transfer, write_en_o SHALL be 0 next cycle; write_addr_o and write_data_o SHALL hold their last values.
REQ-013 grant_o SHALL equal {lsu_ready_o, alu_ready_o}.
REQ-014 Forwarding: read_N_data_o SHALL be 0 if read_N_addr_i==0.
REQ-015 Otherwise, read_N_data_o SHALL be write_data_o if write_en_o==1 and write_addr_o==read_N_addr_i.
REQ-016 Otherwise, read_N_data_o SHALL be read_N_data_i; this path is purely combinational.
REQ-017 Back-to-back transfers to the same address SHALL both reach the write port in order.
REQ-018 Sustained throughput SHALL be one write per cycle, with no bubbles.

Reset
REQ-019 While reset_i=1 at an edge: write_en_o=0, write_addr_o=0, write_data_o=0, and pointer=PRI_LSU.
REQ-020 During reset, ready outputs SHALL be 0 and no transfer SHALL be counted.
REQ-021 Reset mid-operation SHALL discard any accepted-but-unwritten write, so no write_en_o pulse follows reset.

Structure
REQ-022 The shared package SHALL hold DATA_WIDTH/ADDR_BUS_WIDTH defaults, the PRI_ALU/PRI_LSU encoding, and the zero-register address constant.
REQ-023 The forwarding mux SHALL be one sub-module, wb_fwd_mux, instantiated twice (read ports 1 and 2); the arbiter and output register SHALL be in the top module.

Verification
REQ-024 Single ALU: alu_valid=1, addr=5, data=0x0000_00AA for one cycle -> alu_ready=1 that cycle; next cycle write_en_o=1, addr=5, data=0xAA; the cycle after, write_en_o=0.
REQ-025 Contention after reset: both valid (ALU addr=3/0x11, LSU addr=4/0x22), held -> cycle0 LSU granted, cycle1 ALU granted; writes 4/0x22 then 3/0x11 on consecutive cycles; grant_o=10 then 01.
REQ-026 Address 0: lsu_valid=1, addr=0, data=0xFFFF_FFFF -> lsu_ready=1, write_en_o stays 0; a following simultaneous request grants ALU.
REQ-027 Forwarding: write 7/0x1234 accepted; next cycle read_1_addr=7, read_1_data_i=0 -> read_1_data_o=0x1234; read_2_addr=0 -> read_2_data_o=0.
REQ-028 Reset mid-stream: transfer accepted, reset_i=1 at the next edge -> write_en_o=0 and no later pulse; pointer=PRI_LSU, so the next contention grants LSU.
REQ-029 Randomized both-valid streams over 1000 cycles -> write order matches the scoreboard model, grants alternate strictly, and no requester waits more than 1 cycle.
